// File: rtl/rgb_layout_converter.sv
// Rewrites a packed-RGB image (3 words per 2 pixels) into the split red-pair /
// colour-plane layout used by the VGA fetch engine, one 4-pixel group at a time.
module rgb_layout_converter #(
  parameter logic [17:0] SRC_BASE   = 18'd146944,
  parameter logic [17:0] GE_BASE    = 18'd38400,
  parameter logic [17:0] BE_BASE    = 18'd57600,
  parameter logic [17:0] GO_BASE    = 18'd76800,
  parameter logic [17:0] BO_BASE    = 18'd96000,
  parameter int          NUM_GROUPS = 19200
) (
  input  logic        Clock_50,
  input  logic        Resetn,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5, S_DR0, S_DR1,
    S_WR0, S_WR1, S_WR2, S_WR3, S_WR4, S_WR5, S_FINISH
  } state_t;

  localparam logic [14:0] K_LAST = 15'(NUM_GROUPS - 1);

  state_t            state_q, state_d;
  logic [14:0]       k_q, k_d;
  logic [17:0]       src_q, src_d;
  logic [17:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_n_q, we_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [5:0][15:0]  wbuf_q;
  logic [17:0]       red_addr, koff;

  assign red_addr = {2'b00, k_q, 1'b0};
  assign koff     = {3'b000, k_q};

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    src_d   = src_q;
    case (state_q)
      S_IDLE: if (Start) begin
        state_d = S_RD0;
        k_d     = '0;
        src_d   = SRC_BASE;
      end
      S_RD0: state_d = S_RD1;
      S_RD1: state_d = S_RD2;
      S_RD2: state_d = S_RD3;
      S_RD3: state_d = S_RD4;
      S_RD4: state_d = S_RD5;
      S_RD5: state_d = S_DR0;
      S_DR0: state_d = S_DR1;
      S_DR1: state_d = S_WR0;
      S_WR0: state_d = S_WR1;
      S_WR1: state_d = S_WR2;
      S_WR2: state_d = S_WR3;
      S_WR3: state_d = S_WR4;
      S_WR4: state_d = S_WR5;
      S_WR5: if (k_q == K_LAST) begin
        state_d = S_FINISH;
      end else begin
        state_d = S_RD0;
        k_d     = k_q + 15'd1;
        src_d   = src_q + 18'd6;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Port values are computed for the state being entered so they are
  // registered and line up with that state's cycle. k only changes on
  // entry to RD0, so k_q is the current group for every write.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_n_d  = 1'b1;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    case (state_d)
      S_IDLE: busy_d = 1'b0;
      S_RD0:  addr_d = src_d;
      S_RD1:  addr_d = src_d + 18'd1;
      S_RD2:  addr_d = src_d + 18'd2;
      S_RD3:  addr_d = src_d + 18'd3;
      S_RD4:  addr_d = src_d + 18'd4;
      S_RD5:  addr_d = src_d + 18'd5;
      S_WR0: begin
        we_n_d  = 1'b0;
        addr_d  = red_addr;
        wdata_d = {wbuf_q[0][15:8], wbuf_q[1][7:0]};
      end
      S_WR1: begin
        we_n_d  = 1'b0;
        addr_d  = red_addr + 18'd1;
        wdata_d = {wbuf_q[3][15:8], wbuf_q[4][7:0]};
      end
      S_WR2: begin
        we_n_d  = 1'b0;
        addr_d  = GE_BASE + koff;
        wdata_d = {wbuf_q[0][7:0], wbuf_q[3][7:0]};
      end
      S_WR3: begin
        we_n_d  = 1'b0;
        addr_d  = BE_BASE + koff;
        wdata_d = {wbuf_q[1][15:8], wbuf_q[4][15:8]};
      end
      S_WR4: begin
        we_n_d  = 1'b0;
        addr_d  = GO_BASE + koff;
        wdata_d = {wbuf_q[2][15:8], wbuf_q[5][15:8]};
      end
      S_WR5: begin
        we_n_d  = 1'b0;
        addr_d  = BO_BASE + koff;
        wdata_d = {wbuf_q[2][7:0], wbuf_q[5][7:0]};
      end
      S_FINISH: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock_50) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      src_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      // Read data returns two cycles after its address was on the port.
      case (state_q)
        S_RD2:   wbuf_q[0] <= SRAM_read_data;
        S_RD3:   wbuf_q[1] <= SRAM_read_data;
        S_RD4:   wbuf_q[2] <= SRAM_read_data;
        S_RD5:   wbuf_q[3] <= SRAM_read_data;
        S_DR0:   wbuf_q[4] <= SRAM_read_data;
        S_DR1:   wbuf_q[5] <= SRAM_read_data;
        default: ;
      endcase
    end
  end

  assign Busy            = busy_q;
  assign Done            = done_q;
  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;

endmodule

// File: tb/tb_rgb_layout_converter.sv
// Directed bench: 3-group conversion from SRC_BASE=100 against a 2-cycle-latency
// SRAM model, with start-ignore and mid-run reset scenarios.
module tb_rgb_layout_converter;

  localparam int NG  = 3;
  localparam int SRC = 100;
  localparam int WIN = 60;

  logic        clk = 1'b0;
  logic        Resetn, Start;
  logic        Busy, Done, SRAM_we_n;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data, SRAM_read_data;

  always #10 clk = ~clk;

  rgb_layout_converter #(.SRC_BASE(18'(SRC)), .NUM_GROUPS(NG)) dut (
    .Clock_50(clk), .Resetn(Resetn), .Start(Start), .Busy(Busy), .Done(Done),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data)
  );

  // SRAM model: data for the address of cycle c appears in cycle c+2
  logic [15:0] src_mem [0:17];
  logic [15:0] rd_p1, rd_p2;
  assign SRAM_read_data = rd_p2;
  always @(posedge clk) begin
    if (SRAM_address >= 18'(SRC) && SRAM_address < 18'(SRC + 18))
      rd_p1 <= src_mem[int'(SRAM_address) - SRC];
    else
      rd_p1 <= 16'h0000;
    rd_p2 <= rd_p1;
  end

  logic [15:0] exp_wd [0:17];
  logic [17:0] exp_wa [0:17];

  logic [17:0] a_addr [0:WIN];
  logic [15:0] a_wd   [0:WIN];
  logic        a_we   [0:WIN];
  logic        a_busy [0:WIN];
  logic        a_done [0:WIN];

  int n_cmp = 0;
  int n_err = 0;

  // Start is raised at rel 0; extra pulses at p1/p2 and optionally in the Done
  // cycle; Resetn drops for one cycle at rst_rel. Samples outputs per cycle.
  task automatic run_conv(input int p1, input int p2, input bit p_done, input int rst_rel);
    for (int r = 0; r <= WIN; r++) begin
      if (r > 0) begin @(posedge clk); #1; end
      a_addr[r] = SRAM_address;
      a_wd[r]   = SRAM_write_data;
      a_we[r]   = SRAM_we_n;
      a_busy[r] = Busy;
      a_done[r] = Done;
      Start  = (r == 0) || (r == p1) || (r == p2) || (p_done && Done);
      Resetn = (r != rst_rel);
    end
    Start  = 1'b0;
    Resetn = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    Resetn = 1'b0;
    Start  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (SRAM_we_n !== 1'b1) begin n_err++; $display("FAIL reset_we_n got %b want 1", SRAM_we_n); end
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", Busy); end
      n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", Done); end
      n_cmp++; if (SRAM_address !== 18'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", SRAM_address); end
    end
    Resetn = 1'b1;
    Start  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (Busy !== 1'b0 || SRAM_we_n !== 1'b1) begin
        n_err++; $display("FAIL reset_no_activity busy=%b we_n=%b want 0/1", Busy, SRAM_we_n);
      end
    end
  endtask

  task automatic test_conversion;
    int nwe, nd;
    run_conv(-1, -1, 1'b0, -1);
    n_cmp++; if (a_busy[0] !== 1'b0) begin n_err++; $display("FAIL conv_busy_t got %b want 0", a_busy[0]); end
    n_cmp++; if (a_busy[1] !== 1'b1) begin n_err++; $display("FAIL conv_busy_t1 got %b want 1", a_busy[1]); end
    for (int g = 0; g < NG; g++) begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++; if (a_addr[14*g+1+i] !== 18'(SRC + 6*g + i) || a_we[14*g+1+i] !== 1'b1) begin
          n_err++; $display("FAIL conv_rd g%0d w%0d addr=%0d we_n=%b want %0d/1", g, i, a_addr[14*g+1+i], a_we[14*g+1+i], SRC + 6*g + i);
        end
      end
      for (int i = 7; i < 9; i++) begin
        n_cmp++; if (a_addr[14*g+i] !== 18'(SRC + 6*g + 5) || a_we[14*g+i] !== 1'b1) begin
          n_err++; $display("FAIL conv_drain g%0d addr=%0d we_n=%b want %0d/1", g, a_addr[14*g+i], a_we[14*g+i], SRC + 6*g + 5);
        end
      end
      for (int j = 0; j < 6; j++) begin
        n_cmp++; if (a_we[14*g+9+j] !== 1'b0 || a_addr[14*g+9+j] !== exp_wa[6*g+j] || a_wd[14*g+9+j] !== exp_wd[6*g+j]) begin
          n_err++; $display("FAIL conv_wr g%0d j%0d we_n=%b addr=%0d data=%h want 0/%0d/%h", g, j,
                            a_we[14*g+9+j], a_addr[14*g+9+j], a_wd[14*g+9+j], exp_wa[6*g+j], exp_wd[6*g+j]);
        end
      end
    end
    nwe = 0; nd = 0;
    for (int r = 0; r <= WIN; r++) begin
      if (a_we[r] === 1'b0) nwe++;
      if (a_done[r] === 1'b1) nd++;
    end
    n_cmp++; if (nwe != 18) begin n_err++; $display("FAIL conv_we_count got %0d want 18", nwe); end
    n_cmp++; if (a_done[43] !== 1'b1 || a_busy[43] !== 1'b0) begin
      n_err++; $display("FAIL conv_done_t43 done=%b busy=%b want 1/0", a_done[43], a_busy[43]);
    end
    n_cmp++; if (nd != 1) begin n_err++; $display("FAIL conv_done_count got %0d want 1", nd); end
    n_cmp++; if (a_done[15] !== 1'b0) begin n_err++; $display("FAIL conv_no_early_done got %b want 0", a_done[15]); end
  endtask

  task automatic test_start_ignored;
    int nd, nbusy;
    run_conv(5, 30, 1'b1, -1);
    for (int g = 0; g < NG; g++)
      for (int j = 0; j < 6; j++) begin
        n_cmp++; if (a_we[14*g+9+j] !== 1'b0 || a_addr[14*g+9+j] !== exp_wa[6*g+j] || a_wd[14*g+9+j] !== exp_wd[6*g+j]) begin
          n_err++; $display("FAIL ign_wr g%0d j%0d we_n=%b addr=%0d data=%h want 0/%0d/%h", g, j,
                            a_we[14*g+9+j], a_addr[14*g+9+j], a_wd[14*g+9+j], exp_wa[6*g+j], exp_wd[6*g+j]);
        end
      end
    nd = 0; nbusy = 0;
    for (int r = 0; r <= WIN; r++) begin
      if (a_done[r] === 1'b1) nd++;
      if (r > 43 && a_busy[r] !== 1'b0) nbusy++;
    end
    n_cmp++; if (nd != 1 || a_done[43] !== 1'b1) begin n_err++; $display("FAIL ign_done count=%0d done43=%b want 1/1", nd, a_done[43]); end
    n_cmp++; if (nbusy != 0) begin n_err++; $display("FAIL ign_restart busy_cycles=%0d want 0", nbusy); end
  endtask

  task automatic test_mid_reset;
    int nd, nwe;
    run_conv(-1, -1, 1'b0, 40);
    n_cmp++; if (a_we[40] !== 1'b0 || a_addr[40] !== 18'd57602) begin
      n_err++; $display("FAIL mrst_wr3 we_n=%b addr=%0d want 0/57602", a_we[40], a_addr[40]);
    end
    n_cmp++; if (a_busy[41] !== 1'b0 || a_we[41] !== 1'b1 || a_addr[41] !== 18'd0) begin
      n_err++; $display("FAIL mrst_after busy=%b we_n=%b addr=%0d want 0/1/0", a_busy[41], a_we[41], a_addr[41]);
    end
    nd = 0; nwe = 0;
    for (int r = 0; r <= WIN; r++) begin
      if (a_done[r] === 1'b1) nd++;
      if (r > 40 && a_we[r] !== 1'b1) nwe++;
    end
    n_cmp++; if (nd != 0) begin n_err++; $display("FAIL mrst_no_done got %0d want 0", nd); end
    n_cmp++; if (nwe != 0) begin n_err++; $display("FAIL mrst_no_writes got %0d want 0", nwe); end
    idle_cycles(3);
    run_conv(-1, -1, 1'b0, -1);
    for (int g = 0; g < NG; g++)
      for (int j = 0; j < 6; j++) begin
        n_cmp++; if (a_we[14*g+9+j] !== 1'b0 || a_addr[14*g+9+j] !== exp_wa[6*g+j] || a_wd[14*g+9+j] !== exp_wd[6*g+j]) begin
          n_err++; $display("FAIL mrst_rerun_wr g%0d j%0d we_n=%b addr=%0d data=%h want 0/%0d/%h", g, j,
                            a_we[14*g+9+j], a_addr[14*g+9+j], a_wd[14*g+9+j], exp_wa[6*g+j], exp_wd[6*g+j]);
        end
      end
    n_cmp++; if (a_done[43] !== 1'b1) begin n_err++; $display("FAIL mrst_rerun_done got %b want 1", a_done[43]); end
  endtask

  initial begin
    src_mem[0]  = 16'h1122; src_mem[1]  = 16'h3344; src_mem[2]  = 16'h5566;
    src_mem[3]  = 16'h7788; src_mem[4]  = 16'h99AA; src_mem[5]  = 16'hBBCC;
    src_mem[6]  = 16'h0102; src_mem[7]  = 16'h0304; src_mem[8]  = 16'h0506;
    src_mem[9]  = 16'h0708; src_mem[10] = 16'h090A; src_mem[11] = 16'h0B0C;
    src_mem[12] = 16'hA0A1; src_mem[13] = 16'hA2A3; src_mem[14] = 16'hA4A5;
    src_mem[15] = 16'hA6A7; src_mem[16] = 16'hA8A9; src_mem[17] = 16'hAAAB;
    // Hand-unpacked: {R0,R1},{R2,R3},{G0,G2},{B0,B2},{G1,G3},{B1,B3}
    exp_wd[0]  = 16'h1144; exp_wd[1]  = 16'h77AA; exp_wd[2]  = 16'h2288;
    exp_wd[3]  = 16'h3399; exp_wd[4]  = 16'h55BB; exp_wd[5]  = 16'h66CC;
    exp_wd[6]  = 16'h0104; exp_wd[7]  = 16'h070A; exp_wd[8]  = 16'h0208;
    exp_wd[9]  = 16'h0309; exp_wd[10] = 16'h050B; exp_wd[11] = 16'h060C;
    exp_wd[12] = 16'hA0A3; exp_wd[13] = 16'hA6A9; exp_wd[14] = 16'hA1A7;
    exp_wd[15] = 16'hA2A8; exp_wd[16] = 16'hA4AA; exp_wd[17] = 16'hA5AB;
    for (int g = 0; g < NG; g++) begin
      exp_wa[6*g+0] = 18'(2*g);
      exp_wa[6*g+1] = 18'(2*g + 1);
      exp_wa[6*g+2] = 18'(38400 + g);
      exp_wa[6*g+3] = 18'(57600 + g);
      exp_wa[6*g+4] = 18'(76800 + g);
      exp_wa[6*g+5] = 18'(96000 + g);
    end
    Resetn = 1'b0;
    Start  = 1'b0;
    test_reset();
    idle_cycles(2);
    test_conversion();
    idle_cycles(3);
    test_start_ignored();
    idle_cycles(3);
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
